// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// master = operand source and result sink, slave = addsub_pipe.
interface addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, op, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, op, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/sub: one SLICE of the carry chain per stage,
// valid/ready on both ends with a global stall.
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_pipe_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_z;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_bx  [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic              r_ovf;

    logic [STAGES-1:0] w_nx_vld;
    logic [STAGES-1:0] w_nx_c;
    logic [STAGES-1:0] w_nx_z;
    logic [WIDTH-1:0]  w_nx_a   [STAGES];
    logic [WIDTH-1:0]  w_nx_bx  [STAGES];
    logic [WIDTH-1:0]  w_nx_sum [STAGES];
    logic              w_nx_ovf;

    logic              w_stall;
    logic [WIDTH-1:0]  w_bx0;
    logic              w_c0;

    assign w_stall = r_vld[STAGES-1] & ~bus.out_ready;
    assign w_bx0   = bus.b ^ {WIDTH{bus.op[0]}};

    always_comb begin
        w_c0 = 1'b0;
        unique case (bus.op)
            2'b00: w_c0 = 1'b0;
            2'b01: w_c0 = 1'b1;
            2'b10: w_c0 = bus.cin;
            2'b11: w_c0 = ~bus.cin;
        endcase
    end

    always_comb begin : p_next
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_bx_in;
        logic [WIDTH-1:0] w_sum_in;
        logic             w_c_in;
        logic             w_z_in;
        logic             w_v_in;
        logic [SLICE:0]   w_slice;
        int               w_kp;
        w_nx_vld = '0;
        w_nx_c   = '0;
        w_nx_z   = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_kp = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                w_a_in   = bus.a;
                w_bx_in  = w_bx0;
                w_sum_in = '0;
                w_c_in   = w_c0;
                w_z_in   = 1'b1;
                w_v_in   = bus.in_valid;
            end else begin
                w_a_in   = r_a[w_kp];
                w_bx_in  = r_bx[w_kp];
                w_sum_in = r_sum[w_kp];
                w_c_in   = r_c[w_kp];
                w_z_in   = r_z[w_kp];
                w_v_in   = r_vld[w_kp];
            end
            w_slice = {1'b0, w_a_in[k*SLICE +: SLICE]}
                    + {1'b0, w_bx_in[k*SLICE +: SLICE]}
                    + {{SLICE{1'b0}}, w_c_in};
            w_nx_a[k]   = w_a_in;
            w_nx_bx[k]  = w_bx_in;
            w_nx_sum[k] = w_sum_in;
            w_nx_sum[k][k*SLICE +: SLICE] = w_slice[SLICE-1:0];
            w_nx_c[k]   = w_slice[SLICE];
            w_nx_z[k]   = w_z_in & ~|w_slice[SLICE-1:0];
            w_nx_vld[k] = w_v_in;
        end
        // sum bit = a ^ bx ^ carry-in, so the carry into the MSB is recoverable
        w_nx_ovf = w_nx_a[STAGES-1][WIDTH-1]
                 ^ w_nx_bx[STAGES-1][WIDTH-1]
                 ^ w_nx_sum[STAGES-1][WIDTH-1]
                 ^ w_nx_c[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_c   <= '0;
            r_z   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_bx[k]  <= '0;
                r_sum[k] <= '0;
            end
        end else if (!w_stall) begin
            r_vld <= w_nx_vld;
            r_c   <= w_nx_c;
            r_z   <= w_nx_z;
            r_ovf <= w_nx_ovf;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_nx_a[k];
                r_bx[k]  <= w_nx_bx[k];
                r_sum[k] <= w_nx_sum[k];
            end
        end
    end

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.sum       = r_sum[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.zero      = r_z[STAGES-1];
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, STAGES=4) with an
// arithmetic reference model and an in-order expected-result queue.
module tb_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchk = 0;
    int   nfail = 0;
    logic [18:0] q[$];

    addsub_pipe_if #(.WIDTH(16)) bus ();

    addsub_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {sum, cout, ovf, zero} from plain integer arithmetic
    function automatic logic [18:0] model(logic [15:0] a, logic [15:0] b,
                                          logic [1:0] op, logic ci);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int c = int'(ci);
        int ur;
        int sr;
        logic co;
        logic [15:0] s;
        case (op)
            2'd0: begin ur = ua + ub; sr = sa + sb; co = (ur > 65535); end
            2'd1: begin ur = ua - ub; sr = sa - sb; co = (ur >= 0); end
            2'd2: begin ur = ua + ub + c; sr = sa + sb + c; co = (ur > 65535); end
            default: begin ur = ua - ub - c; sr = sa - sb - c; co = (ur >= 0); end
        endcase
        s = ur[15:0];
        return {s, co, (sr > 32767) || (sr < -32768), s == 16'h0};
    endfunction

    function automatic logic [18:0] act();
        return {bus.sum, bus.cout, bus.ovf, bus.zero};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        nchk++;
        if ({bus.out_valid, act()} !== 20'h0) begin
            nfail++;
            $display("FAIL reset_outputs: got %h want 0", {bus.out_valid, act()});
        end
        nchk++;
        if (bus.in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [7] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h00FF, 16'h0005};
        logic [15:0] tb [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0003};
        logic [1:0]  to [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [18:0] te [7] = '{{16'h1235, 3'b000}, {16'h8000, 3'b010},
                                {16'h0000, 3'b101}, {16'hFFFF, 3'b000},
                                {16'h7FFF, 3'b110}, {16'h0100, 3'b000},
                                {16'h0001, 3'b100}};
        int n;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid = 1'b1;
            bus.a = ta[i];
            bus.b = tb[i];
            bus.op = to[i];
            bus.cin = tc[i];
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            n = 1;
            while (!bus.out_valid && n < 20) begin
                @(posedge clk);
                #1 n++;
            end
            nchk++;
            if (n !== 4) begin
                nfail++;
                $display("FAIL latency_%0d: got %0d want 4", i, n);
            end
            nchk++;
            if (act() !== te[i]) begin
                nfail++;
                $display("FAIL directed_%0d: got %h want %h", i, act(), te[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int extra = 0;
        logic [15:0] va;
        logic [15:0] vb;
        logic [1:0]  vo;
        logic        vc;
        q.delete();
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 6) begin
                va = 16'h1000 * 16'(sent + 1) + 16'h0F0F;
                vb = 16'h0333 * 16'(sent + 2);
                vo = 2'(sent);
                vc = sent[0];
                bus.in_valid = 1'b1;
                bus.a = va;
                bus.b = vb;
                bus.op = vo;
                bus.cin = vc;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                nchk++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    nfail++;
                    $display("FAIL b2b_stall_c%0d: in_ready=%b out_valid=%b want 0/1", cyc, bus.in_ready, bus.out_valid);
                end
            end
            if (bus.out_valid) begin
                nchk++;
                if (q.size() == 0 || act() !== q[0]) begin
                    nfail++;
                    $display("FAIL b2b_result_c%0d: got %h want %h", cyc, act(), (q.size() != 0) ? q[0] : 19'h0);
                end
                if (bus.out_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(va, vb, vo, vc));
                sent++;
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        nchk++;
        if (got !== 6 || extra !== 0 || q.size() !== 0) begin
            nfail++;
            $display("FAIL b2b_count: got=%0d extra=%0d left=%0d want 6/0/0", got, extra, q.size());
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        int got = 0;
        int sent = 0;
        logic have = 1'b0;
        logic [15:0] va = '0;
        logic [15:0] vb = '0;
        logic [1:0]  vo = '0;
        logic        vc = 1'b0;
        q.delete();
        while (cyc < 400) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 300) || ($urandom_range(3) != 0);
            if (!have && cyc < 300 && $urandom_range(3) != 0) begin
                have = 1'b1;
                va = ($urandom_range(3) == 0) ? 16'h7FFF + 16'($urandom_range(2)) : 16'($urandom);
                vb = ($urandom_range(3) == 0) ? 16'($urandom_range(1)) : 16'($urandom);
                vo = 2'($urandom);
                vc = 1'($urandom);
                if ($urandom_range(7) == 0) vb = va;
            end
            bus.in_valid = have;
            bus.a = va;
            bus.b = vb;
            bus.op = vo;
            bus.cin = vc;
            #1;
            if (bus.out_valid) begin
                nchk++;
                if (q.size() == 0 || act() !== q[0]) begin
                    nfail++;
                    $display("FAIL rand_result_c%0d: got %h want %h", cyc, act(), (q.size() != 0) ? q[0] : 19'h0);
                end
                if (bus.out_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    got++;
                end
            end
            if (have && bus.in_ready) begin
                q.push_back(model(va, vb, vo, vc));
                have = 1'b0;
                sent++;
            end
            cyc++;
            if (cyc > 300 && q.size() == 0 && !bus.out_valid) break;
        end
        bus.in_valid = 1'b0;
        nchk++;
        if (q.size() !== 0 || got !== sent) begin
            nfail++;
            $display("FAIL rand_drain: left=%0d got=%0d sent=%0d", q.size(), got, sent);
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        int n;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 16'h1111 * 16'(i + 1);
            bus.b = 16'h2222;
            bus.op = 2'd0;
            bus.cin = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        nchk++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 16'h3333) begin
            nfail++;
            $display("FAIL midrst_before: out_valid=%b sum=%h want 1/3333", bus.out_valid, bus.sum);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({bus.out_valid, act()} !== 20'h0) begin
            nfail++;
            $display("FAIL midrst_outputs: got %h want 0", {bus.out_valid, act()});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        nchk++;
        if (seen !== 0) begin
            nfail++;
            $display("FAIL midrst_ghost: got %0d results want 0", seen);
        end
        bus.in_valid = 1'b1;
        bus.a = 16'h0100;
        bus.b = 16'h0200;
        bus.op = 2'd0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        nchk++;
        if (n !== 4 || act() !== {16'h0300, 3'b000}) begin
            nfail++;
            $display("FAIL midrst_next: lat=%0d res=%h want 4/%h", n, act(), {16'h0300, 3'b000});
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
